// File: rtl/wdg_kick_generator_if.sv
// Watchdog kick generator bundle: supervision controls in, kick and status out.
// master drives the controls (host side), slave is the generator itself.
interface wdg_kick_generator_if #(
  parameter int NUM_TASKS = 4
);
  logic                 enable;
  logic [NUM_TASKS-1:0] task_alive;
  logic                 force_stop;
  logic                 rearm;
  logic                 wdg_kick;
  logic [NUM_TASKS-1:0] missing_o;
  logic [3:0]           miss_cnt_o;
  logic [15:0]          kick_cnt_o;
  logic                 starved_o;

  modport master (
    output enable, task_alive, force_stop, rearm,
    input  wdg_kick, missing_o, miss_cnt_o, kick_cnt_o, starved_o
  );

  modport slave (
    input  enable, task_alive, force_stop, rearm,
    output wdg_kick, missing_o, miss_cnt_o, kick_cnt_o, starved_o
  );
endinterface

// File: rtl/wdg_kick_generator.sv
// Kicks the ESD watchdog only when every supervised task checked in this period.
// Registered outputs, kick starts the cycle after evaluation; no backpressure.
module wdg_kick_generator #(
  parameter int CLK_HZ            = 24000000,
  parameter int KICK_PERIOD_MS    = 100,
  parameter int NUM_TASKS         = 4,
  parameter int KICK_PULSE_CYCLES = 4,
  parameter int MAX_MISSES        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  wdg_kick_generator_if.slave   bus
);
  localparam int P  = CLK_HZ / 1000 * KICK_PERIOD_MS;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int PW = $clog2(KICK_PULSE_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] STARVE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST     = CW'(P - 1);
  localparam logic [PW-1:0] PULSE_RELOAD = PW'(KICK_PULSE_CYCLES - 1);
  localparam logic [3:0]    MISS_MAX     = 4'(MAX_MISSES);

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [NUM_TASKS-1:0] seen;
  logic [NUM_TASKS-1:0] seen_now;
  logic [PW-1:0]        pulse_cnt;
  logic                 kick;
  logic                 starved;
  logic [NUM_TASKS-1:0] missing;
  logic [3:0]           miss_cnt;
  logic [3:0]           miss_next;
  logic [15:0]          kick_cnt;
  logic                 run_ok;

  // A check-in on the evaluation cycle itself still counts for this period.
  assign seen_now  = seen | bus.task_alive;
  assign run_ok    = bus.enable && !bus.force_stop;
  assign miss_next = (miss_cnt >= MISS_MAX) ? MISS_MAX : miss_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      seen      <= '0;
      pulse_cnt <= '0;
      kick      <= 1'b0;
      starved   <= 1'b0;
      missing   <= '0;
      miss_cnt  <= '0;
      kick_cnt  <= '0;
    end else begin
      // Kick drops unless RUN continues with pulse time left, so leaving RUN cuts it at once.
      kick <= 1'b0;
      case (state)
        IDLE: begin
          cnt       <= '0;
          seen      <= '0;
          miss_cnt  <= '0;
          pulse_cnt <= '0;
          if (run_ok) begin
            state <= RUN;
          end else if (bus.enable) begin
            state   <= STARVE;
            starved <= 1'b1;
          end
        end
        RUN: begin
          if (bus.force_stop) begin
            state     <= STARVE;
            starved   <= 1'b1;
            pulse_cnt <= '0;
          end else if (!bus.enable) begin
            state     <= IDLE;
            cnt       <= '0;
            seen      <= '0;
            miss_cnt  <= '0;
            pulse_cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            seen    <= '0;
            missing <= ~seen_now;
            if (&seen_now) begin
              miss_cnt  <= '0;
              kick_cnt  <= kick_cnt + 16'd1;
              kick      <= 1'b1;
              pulse_cnt <= PULSE_RELOAD;
            end else begin
              miss_cnt  <= miss_next;
              pulse_cnt <= '0;
              if (miss_next >= MISS_MAX) begin
                state   <= STARVE;
                starved <= 1'b1;
              end
            end
          end else begin
            cnt  <= cnt + CW'(1);
            seen <= seen_now;
            if (pulse_cnt != '0) begin
              kick      <= 1'b1;
              pulse_cnt <= pulse_cnt - PW'(1);
            end
          end
        end
        default: begin
          // Sticky: only an explicit rearm with supervision enabled leaves STARVE.
          if (bus.rearm && run_ok) begin
            state    <= RUN;
            starved  <= 1'b0;
            cnt      <= '0;
            seen     <= '0;
            miss_cnt <= '0;
            missing  <= '0;
          end
        end
      endcase
    end
  end

  assign bus.wdg_kick   = kick;
  assign bus.starved_o  = starved;
  assign bus.missing_o  = missing;
  assign bus.miss_cnt_o = miss_cnt;
  assign bus.kick_cnt_o = kick_cnt;
endmodule
